// File: rtl/mdio_xfer.sv
// MDIO management-frame master: sends one 64-bit clause-22 read or write frame
// per request, generating MDC at clock/2 and capturing read data into rd_data.
module mdio_xfer #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        rd_request,
  input  logic        wr_request,
  input  logic [15:0] wr_data,
  output logic        ready,
  output logic [15:0] rd_data,
  inout  wire         mdio_pin,
  output logic        mdc_pin
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t      state, next_state;
  logic [5:0]  bit_cnt;
  logic        phase;
  logic        op_write;
  logic [4:0]  addr_q;
  logic [15:0] data_q;
  logic [15:0] rx_shift;
  logic [63:0] frame;
  logic        mdio_o;
  logic        mdio_oe;
  logic        accept;

  assign accept = (state == IDLE) && (rd_request || wr_request);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (phase && bit_cnt == 6'd63) next_state = GAP;
      GAP:     if (phase) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // phase doubles as the low/high half of a bit in SHIFT and as the 2-cycle gap timer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= 6'd0;
      phase    <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 16'h0000;
      rx_shift <= 16'h0000;
      rd_data  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bit_cnt  <= 6'd0;
            phase    <= 1'b0;
            op_write <= wr_request;
            addr_q   <= addr;
            data_q   <= wr_data;
          end
        end
        SHIFT: begin
          phase <= ~phase;
          if (phase && bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          if (phase && !op_write && bit_cnt >= 6'd48)
            rx_shift <= {rx_shift[14:0], mdio_pin};
        end
        GAP: begin
          phase <= ~phase;
          if (phase) begin
            bit_cnt <= 6'd0;
            if (!op_write) rd_data <= rx_shift;
          end
        end
        default: begin
          phase <= 1'b0;
        end
      endcase
    end
  end

  // bit_cnt only advances at the start of a low phase, so the driven bit is stable for the whole bit
  assign frame = {32'hFFFF_FFFF, 2'b01, (op_write ? 2'b01 : 2'b10), PHY_ADDR, addr_q,
                  (op_write ? 2'b10 : 2'b00), (op_write ? data_q : 16'h0000)};

  assign mdio_o   = frame[6'd63 - bit_cnt];
  assign mdio_oe  = (state == SHIFT) && (op_write || bit_cnt < 6'd46);
  assign mdio_pin = mdio_oe ? mdio_o : 1'bz;
  assign ready    = (state == IDLE);
  assign mdc_pin  = (state == SHIFT) && phase;

endmodule
